// File: rtl/insn_fetch.sv
// insn_fetch: instruction prefetch unit with a DEPTH-entry queue and one outstanding memory request
// Ports: clk, reset_n (async active-low); mem_req/mem_addr out, mem_ack/mem_data in (memory handshake);
// redirect/redirect_pc in (flush and refetch); insn_valid/insn/insn_pc out, insn_ready in (decode side).
// Option: define FETCH_STALL_COUNT_EN to add the stall_count output.
module insn_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    input  logic        insn_ready
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0] stall_count
`endif
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
    state_t state, state_n;
    logic [31:0] fetch_pc, pc_n, addr_n;
    logic [31:0] q_insn [DEPTH];
    logic [31:0] q_pc [DEPTH];
    logic [PW-1:0] head, tail;
    logic [3:0] count;
    logic push, pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign insn_valid = count != 4'd0;
    assign insn = q_insn[head];
    assign insn_pc = q_pc[head];
    assign pop = insn_valid && insn_ready && !redirect;

    // Redirect never pushes; a pending request is either discarded now (ack) or via DROP.
    always_comb begin
        state_n = state;
        addr_n = mem_addr;
        pc_n = redirect ? redirect_pc : fetch_pc;
        push = 1'b0;
        case (state)
            IDLE: if (!redirect && count < 4'(DEPTH)) begin
                state_n = WAIT;
                addr_n = fetch_pc;
            end
            WAIT: if (mem_ack) begin
                state_n = IDLE;
                if (!redirect) begin
                    push = 1'b1;
                    pc_n = mem_addr + 32'd1;
                    addr_n = mem_addr + 32'd1;
                    state_n = count + 4'd1 - {3'b0, pop} < 4'(DEPTH) ? WAIT : IDLE;
                end
            end else if (redirect) state_n = DROP;
            DROP: state_n = mem_ack ? IDLE : DROP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            mem_req <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_n;
            mem_req <= state_n != IDLE;
            mem_addr <= addr_n;
            fetch_pc <= pc_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_insn[i] <= '0;
                q_pc[i] <= '0;
            end
        end else if (redirect) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_insn[tail] <= mem_data;
                q_pc[tail] <= mem_addr;
                tail <= wrap_inc(tail);
            end
            if (pop) head <= wrap_inc(head);
            count <= count + {3'b0, push} - {3'b0, pop};
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_count <= '0;
        else if (insn_ready && !insn_valid && stall_count != '1) stall_count <= stall_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_insn_fetch.sv
// tb_insn_fetch: directed and random checks of insn_fetch against a queue-based reference model
module tb_insn_fetch;
    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_1000;
    logic clk = 1'b0, reset_n = 1'b0, mem_ack = 1'b0, redirect = 1'b0, insn_ready = 1'b0;
    logic [31:0] mem_data = '0, redirect_pc = '0;
    logic mem_req, insn_valid;
    logic [31:0] mem_addr, insn, insn_pc;
    logic [31:0] m_stall;
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif
    int n_chk = 0, n_fail = 0, n_push = 0;
    logic [63:0] m_q[$];
    logic [31:0] m_pc, hold_addr;
    logic m_drop, hold;

    insn_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc), .insn_ready(insn_ready)
`ifdef FETCH_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc = RST_PC;
        m_drop = 1'b0;
        hold = 1'b0;
        m_stall = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, RST_PC);
        chk("rst_valid", 32'(insn_valid), 32'd0);
        chk("rst_insn", insn, 32'd0);
        chk("rst_pc", insn_pc, 32'd0);
`ifdef FETCH_STALL_COUNT_EN
        chk("rst_stall", stall_count, 32'd0);
`endif
        model_reset();
        reset_n = 1'b1;
    endtask

    // Check outputs at the negedge, then advance the model across the next rising edge.
    task automatic tick();
        logic req, ack, rd, valid, rdy;
        logic [31:0] addr, data, rpc;
        mem_data = $urandom;
        chk("insn_valid", 32'(insn_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("insn", insn, m_q[0][63:32]);
            chk("insn_pc", insn_pc, m_q[0][31:0]);
        end
        if (hold) begin
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("addr_hold", mem_addr, hold_addr);
        end
        if (mem_req && mem_ack && !m_drop && !redirect) chk("fetch_addr", mem_addr, m_pc);
`ifdef FETCH_STALL_COUNT_EN
        chk("stall_count", stall_count, m_stall);
`endif
        req = mem_req; ack = mem_ack; rd = redirect; valid = m_q.size() != 0;
        rdy = insn_ready; addr = mem_addr; data = mem_data; rpc = redirect_pc;
        @(posedge clk);
        if (rdy && !valid && m_stall != '1) m_stall = m_stall + 32'd1;
        if (rd) begin
            m_q.delete();
            m_pc = rpc;
            m_drop = req && !ack;
        end else begin
            if (valid && rdy) void'(m_q.pop_front());
            if (req && ack) begin
                if (m_drop) m_drop = 1'b0;
                else begin
                    m_q.push_back({data, addr});
                    m_pc = addr + 32'd1;
                    n_push++;
                    chk("q_bound", 32'(m_q.size() <= DEPTH), 32'd1);
                end
            end
        end
        hold = req && !ack;
        hold_addr = addr;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        do_reset();
        // Zero-wait streaming from reset.
        mem_ack = 1'b1;
        insn_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stream_req", 32'(mem_req), 32'd1);
            chk("stream_addr", mem_addr, RST_PC + 32'(k));
            if (k > 0) begin
                chk("stream_valid", 32'(insn_valid), 32'd1);
                chk("stream_pc", insn_pc, RST_PC + 32'(k - 1));
            end
        end
        // Decode stalled: queue fills, requests stop.
        do_reset();
        insn_ready = 1'b0;
        mem_ack = 1'b1;
        n_push = 0;
        repeat (10) begin
            tick();
            if (insn_valid) chk("stall_head", insn_pc, RST_PC);
        end
        chk("push_count", 32'(n_push), 32'd2);
        chk("full_idle", 32'(mem_req), 32'd0);
        // Redirect while waiting, ack withheld: DROP then refetch.
        do_reset();
        insn_ready = 1'b1;
        mem_ack = 1'b0;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_2000;
        tick();
        redirect = 1'b0;
        chk("drop_req", 32'(mem_req), 32'd1);
        chk("drop_addr", mem_addr, RST_PC);
        repeat (2) begin
            tick();
            chk("drop_req", 32'(mem_req), 32'd1);
            chk("drop_addr", mem_addr, RST_PC);
        end
        mem_ack = 1'b1;
        tick();
        chk("drop_idle", 32'(mem_req), 32'd0);
        chk("drop_valid", 32'(insn_valid), 32'd0);
        tick();
        chk("refetch_req", 32'(mem_req), 32'd1);
        chk("refetch_addr", mem_addr, 32'h0000_2000);
        tick();
        chk("refetch_valid", 32'(insn_valid), 32'd1);
        chk("refetch_pc", insn_pc, 32'h0000_2000);
        // Address wrap.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 8 && !insn_valid; i++) tick();
        chk("wrap_valid", 32'(insn_valid), 32'd1);
        chk("wrap_pc_hi", insn_pc, 32'hFFFF_FFFF);
        tick();
        chk("wrap_valid2", 32'(insn_valid), 32'd1);
        chk("wrap_pc_lo", insn_pc, 32'h0000_0000);
        // Reset mid-request with a late ack.
        mem_ack = 1'b0;
        tick();
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("async_req", 32'(mem_req), 32'd0);
        chk("async_addr", mem_addr, RST_PC);
        chk("async_valid", 32'(insn_valid), 32'd0);
        do_reset();
        tick();
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", mem_addr, RST_PC);
        // Ack withheld after reset with decode ready: stall accounting.
        do_reset();
        mem_ack = 1'b0;
        insn_ready = 1'b1;
        repeat (6) tick();
        mem_ack = 1'b1;
        repeat (3) tick();
        // Random traffic.
        do_reset();
        repeat (1500) begin
            mem_ack = 1'($urandom_range(0, 1));
            insn_ready = $urandom_range(0, 9) < 7;
            redirect = $urandom_range(0, 19) == 0;
            redirect_pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFE : $urandom;
            tick();
        end
        redirect = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
